// File: rtl/vga_pkg.sv
// vga_pkg: shared frame-buffer geometry, RGB444 field layout and
// the control bundle carried alongside each pixel.
package vga_pkg;
    localparam int H_ACT_DEF = 160;
    localparam int V_ACT_DEF = 120;
    localparam int FB_DEPTH  = H_ACT_DEF * V_ACT_DEF;
    localparam int ADDR_W    = 15;
    localparam int RED_LSB   = 8;
    localparam int GRN_LSB   = 4;
    localparam int BLU_LSB   = 0;
    typedef logic [11:0] rgb444_t;
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic nblank;
        logic active;
    } vga_ctl_t;
    // syncs idle high, nothing displayed, outside the window
    localparam vga_ctl_t CTL_IDLE = '{hsync: 1'b1, vsync: 1'b1, nblank: 1'b0, active: 1'b0};
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register with a per-bit reset value.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk25,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: walks the frame buffer in step with the VGA timing stream
// and emits registered RGB444 with syncs aligned to the read latency.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int          H_ACT      = H_ACT_DEF,
    parameter int          V_ACT      = V_ACT_DEF,
    parameter int          RAM_LAT    = 1,
    parameter logic [11:0] BORDER_RGB = 12'h000
) (
    input  logic              clk25,
    input  logic              reset_n,
    input  logic              vga_hsync_in,
    input  logic              vga_vsync_in,
    input  logic              nBlank_in,
    input  logic              activeArea_in,
    output logic [ADDR_W-1:0] frame_addr,
    input  logic [11:0]       frame_pixel,
    output logic [3:0]        vga_red,
    output logic [3:0]        vga_green,
    output logic [3:0]        vga_blue,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              nBlank,
    output logic              frame_start,
    output logic              line_err,
    output logic              overrun
);
    localparam int LAT = RAM_LAT + 2;
    localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(H_ACT * V_ACT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = FRAME_PIX - 1'b1;

    if (RAM_LAT < 1 || RAM_LAT > 4) $error("RAM_LAT must be 1..4");

    logic [ADDR_W-1:0] addr_cnt;
    logic              vsync_q;
    logic              vs_fall;
    logic [7:0]        run_cnt;
    rgb444_t           pix_q;
    rgb444_t           colour_nx;
    vga_ctl_t          ctl_in;
    vga_ctl_t          ctl_d;

    assign vs_fall = vsync_q & ~vga_vsync_in;
    assign ctl_in  = '{hsync: vga_hsync_in, vsync: vga_vsync_in, nblank: nBlank_in, active: activeArea_in};

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            addr_cnt    <= '0;
            frame_addr  <= '0;
            vsync_q     <= 1'b1;
            frame_start <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            vsync_q     <= vga_vsync_in;
            frame_start <= vs_fall;
            if (vs_fall) begin
                // a rewind coinciding with an active sample fetches pixel 0 now
                addr_cnt <= ADDR_W'(activeArea_in);
                overrun  <= 1'b0;
                if (activeArea_in) frame_addr <= '0;
            end else if (activeArea_in) begin
                if (addr_cnt == FRAME_PIX) begin
                    frame_addr <= LAST_ADDR;
                    overrun    <= 1'b1;
                end else begin
                    frame_addr <= addr_cnt;
                    addr_cnt   <= addr_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            run_cnt  <= '0;
            line_err <= 1'b0;
        end else if (activeArea_in) begin
            run_cnt <= (run_cnt == 8'hFF) ? run_cnt : run_cnt + 1'b1;
        end else if (run_cnt != 8'd0) begin
            line_err <= line_err | (run_cnt != 8'(H_ACT));
            run_cnt  <= '0;
        end
    end

    // LAT stages here plus the output register give the full LAT-cycle delay
    vga_delay_line #(
        .WIDTH   (4),
        .DEPTH   (LAT),
        .RST_VAL (CTL_IDLE)
    ) u_ctl_delay (
        .clk25   (clk25),
        .reset_n (reset_n),
        .d       (ctl_in),
        .q       (ctl_d)
    );

    assign colour_nx = ctl_d.active ? pix_q : ctl_d.nblank ? BORDER_RGB : 12'h000;

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            pix_q     <= '0;
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            nBlank    <= 1'b0;
        end else begin
            pix_q     <= frame_pixel;
            vga_red   <= colour_nx[RED_LSB +: 4];
            vga_green <= colour_nx[GRN_LSB +: 4];
            vga_blue  <= colour_nx[BLU_LSB +: 4];
            vga_hsync <= ctl_d.hsync;
            vga_vsync <= ctl_d.vsync;
            nBlank    <= ctl_d.nblank;
        end
    end
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: directed checks of addressing, alignment, status flags
// and read-latency sweep for vga_pixel_fetch.
module tb_vga_pixel_fetch;
    logic        clk25 = 1'b0;
    logic        reset_n = 1'b0;
    logic        hs = 1'b1, vs = 1'b1, nb = 1'b0, act = 1'b0;
    logic [14:0] frame_addr;
    logic [11:0] frame_pixel;
    logic [3:0]  r, g, b;
    logic        hso, vso, nbo, fs, lerr, ovr;
    int          checks = 0;
    int          fails = 0;

    logic [14:0] la [1:4];
    logic [11:0] lp [1:4];
    logic [3:0]  lr [1:4], lg [1:4], lb [1:4];
    logic        lhs [1:4], lvs [1:4], lnb [1:4], lfs [1:4], lle [1:4], lov [1:4];

    always #20 clk25 = ~clk25;

    // single-cycle BRAM whose word at address a holds a
    always_ff @(posedge clk25) frame_pixel <= 12'(frame_addr);

    vga_pixel_fetch dut (
        .clk25(clk25), .reset_n(reset_n),
        .vga_hsync_in(hs), .vga_vsync_in(vs), .nBlank_in(nb), .activeArea_in(act),
        .frame_addr(frame_addr), .frame_pixel(frame_pixel),
        .vga_red(r), .vga_green(g), .vga_blue(b),
        .vga_hsync(hso), .vga_vsync(vso), .nBlank(nbo),
        .frame_start(fs), .line_err(lerr), .overrun(ovr)
    );

    for (genvar n = 1; n <= 4; n++) begin : lat
        logic [11:0] rd [0:3];
        always_ff @(posedge clk25) begin
            rd[0] <= 12'(la[n]);
            for (int i = 1; i < 4; i++) rd[i] <= rd[i-1];
        end
        assign lp[n] = rd[n-1];
        vga_pixel_fetch #(.RAM_LAT(n), .BORDER_RGB(12'hF00)) u (
            .clk25(clk25), .reset_n(reset_n),
            .vga_hsync_in(hs), .vga_vsync_in(vs), .nBlank_in(nb), .activeArea_in(act),
            .frame_addr(la[n]), .frame_pixel(lp[n]),
            .vga_red(lr[n]), .vga_green(lg[n]), .vga_blue(lb[n]),
            .vga_hsync(lhs[n]), .vga_vsync(lvs[n]), .nBlank(lnb[n]),
            .frame_start(lfs[n]), .line_err(lle[n]), .overrun(lov[n])
        );
    end

    task automatic drive(input logic h, input logic v, input logic n, input logic a);
        @(negedge clk25);
        hs = h; vs = v; nb = n; act = a;
        @(posedge clk25);
        #1;
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        repeat (5) drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        @(negedge clk25);
        hs = 1'b1; vs = 1'b1; nb = 1'b0; act = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        int bad = 0;
        reset_dut();
        repeat (20) drive(1'b1, 1'b1, 1'b1, 1'b1);
        reset_dut();
        checks++; if ({r, g, b} !== 12'h000) begin fails++; $display("FAIL reset_rgb: got %h want 000", {r, g, b}); end
        checks++; if ({hso, vso} !== 2'b11) begin fails++; $display("FAIL reset_sync: got %b want 11", {hso, vso}); end
        checks++; if (nbo !== 1'b0) begin fails++; $display("FAIL reset_nblank: got %b want 0", nbo); end
        checks++; if ({fs, lerr, ovr} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {fs, lerr, ovr}); end
        checks++; if (frame_addr !== 15'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", frame_addr); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            if ({r, g, b, nbo} !== 13'd0) bad++;
        end
        checks++; if (bad !== 0) begin fails++; $display("FAIL reset_flush: got %0d stale outputs want 0", bad); end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (frame_addr !== 15'd0) begin fails++; $display("FAIL reset_resume: got %0d want 0", frame_addr); end
    endtask

    task automatic test_full_frame();
        int k = 0, addr_err = 0, pix_err = 0, fs_cnt = 0;
        logic [14:0] pipe [0:3];
        logic [14:0] got = '0, want = '0;
        reset_dut();
        for (int i = 0; i < 4; i++) pipe[i] = {3'b110, 12'h000};
        for (int ln = 0; ln < 136; ln++) begin
            for (int c = 0; c < 200; c++) begin
                logic h, v, n, a;
                logic [11:0] e;
                n = (ln < 130) && (c < 180);
                a = (ln >= 5) && (ln < 125) && (c >= 10) && (c < 170);
                h = !((c >= 185) && (c < 190));
                v = !((ln >= 132) && (ln < 134));
                e = a ? 12'(k) : 12'h000;
                drive(h, v, n, a);
                if (a) begin
                    if (frame_addr !== 15'(k)) addr_err++;
                    k++;
                end
                for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
                pipe[0] = {h, v, n, e};
                if ({hso, vso, nbo, r, g, b} !== pipe[3]) begin
                    if (pix_err == 0) begin got = {hso, vso, nbo, r, g, b}; want = pipe[3]; end
                    pix_err++;
                end
                fs_cnt += int'(fs);
            end
        end
        checks++; if (addr_err !== 0) begin fails++; $display("FAIL frame_addr_seq: got %0d bad addresses want 0", addr_err); end
        checks++; if (pix_err !== 0) begin fails++; $display("FAIL frame_rgb_align: %0d bad cycles, first got %h want %h", pix_err, got, want); end
        checks++; if (lerr !== 1'b0) begin fails++; $display("FAIL frame_line_err: got %b want 0", lerr); end
        checks++; if (ovr !== 1'b0) begin fails++; $display("FAIL frame_overrun: got %b want 0", ovr); end
        checks++; if (fs_cnt !== 1) begin fails++; $display("FAIL frame_start_count: got %0d want 1", fs_cnt); end
    endtask

    task automatic test_rewind();
        reset_dut();
        for (int i = 0; i <= 5000; i++) begin
            if (i > 0 && i % 160 == 0) drive(1'b1, 1'b1, 1'b1, 1'b0);
            drive(1'b1, 1'b1, 1'b1, 1'b1);
        end
        checks++; if (frame_addr !== 15'd5000) begin fails++; $display("FAIL rewind_pre_addr: got %0d want 5000", frame_addr); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (fs !== 1'b1) begin fails++; $display("FAIL rewind_pulse: got %b want 1", fs); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (fs !== 1'b0) begin fails++; $display("FAIL rewind_pulse_end: got %b want 0", fs); end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (frame_addr !== 15'd0) begin fails++; $display("FAIL rewind_addr0: got %0d want 0", frame_addr); end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        checks++; if ({fs, frame_addr} !== {1'b1, 15'd0}) begin fails++; $display("FAIL rewind_collide: got fs=%b addr=%0d want fs=1 addr=0", fs, frame_addr); end
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        checks++; if (frame_addr !== 15'd1) begin fails++; $display("FAIL rewind_collide_next: got %0d want 1", frame_addr); end
    endtask

    task automatic test_short_line();
        reset_dut();
        repeat (160) drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (lerr !== 1'b0) begin fails++; $display("FAIL line_ok: got %b want 0", lerr); end
        repeat (159) drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (lerr !== 1'b0) begin fails++; $display("FAIL line_short_early: got %b want 0", lerr); end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (lerr !== 1'b1) begin fails++; $display("FAIL line_short: got %b want 1", lerr); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (160) drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (lerr !== 1'b1) begin fails++; $display("FAIL line_sticky: got %b want 1", lerr); end
        reset_dut();
        repeat (416) drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (lerr !== 1'b1) begin fails++; $display("FAIL line_run_saturate: got %b want 1", lerr); end
    endtask

    task automatic test_overrun();
        reset_dut();
        repeat (19200) drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if ({ovr, frame_addr} !== {1'b0, 15'd19199}) begin fails++; $display("FAIL overrun_edge: got ovr=%b addr=%0d want ovr=0 addr=19199", ovr, frame_addr); end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (ovr !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b want 1", ovr); end
        repeat (4) drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if ({ovr, frame_addr} !== {1'b1, 15'd19199}) begin fails++; $display("FAIL overrun_hold: got ovr=%b addr=%0d want ovr=1 addr=19199", ovr, frame_addr); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (ovr !== 1'b0) begin fails++; $display("FAIL overrun_clear: got %b want 0", ovr); end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (frame_addr !== 15'd0) begin fails++; $display("FAIL overrun_rewind_addr: got %0d want 0", frame_addr); end
    endtask

    task automatic test_latency();
        int k = 0;
        int err [1:4] = '{0, 0, 0, 0};
        logic vprev = 1'b1;
        logic [14:0] hist [0:99];
        logic [14:0] got [1:4];
        logic [14:0] want [1:4];
        reset_dut();
        for (int n = 0; n < 100; n++) begin
            logic h, v, bl, a;
            logic [11:0] e;
            h  = (n % 11) != 5;
            v  = !((n >= 40) && (n < 43));
            bl = (n % 10) < 7;
            a  = ((n % 10) >= 2) && ((n % 10) <= 5);
            if (vprev && !v) k = 0;
            e = a ? 12'(k) : bl ? 12'hF00 : 12'h000;
            if (a) k++;
            vprev = v;
            hist[n] = {h, v, bl, e};
            drive(h, v, bl, a);
            for (int L = 1; L <= 4; L++) begin
                if (n >= L + 2 && {lhs[L], lvs[L], lnb[L], lr[L], lg[L], lb[L]} !== hist[n-L-2]) begin
                    if (err[L] == 0) begin got[L] = {lhs[L], lvs[L], lnb[L], lr[L], lg[L], lb[L]}; want[L] = hist[n-L-2]; end
                    err[L]++;
                end
            end
        end
        for (int L = 1; L <= 4; L++) begin
            checks++;
            if (err[L] !== 0) begin
                fails++;
                $display("FAIL latency_ram_lat%0d: %0d bad cycles, first got %h want %h", L, err[L], got[L], want[L]);
            end
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_frame();
        test_rewind();
        test_short_line();
        test_overrun();
        test_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
